// File: rtl/btn_pair_debounce.sv
// Two independent raw-button cleaners: 2-flop synchronizer plus saturating debounce counter.
// Latency DEBOUNCE_CYCLES+2 edges from raw change to level/pulse; no backpressure, free-running.
module btn_pair_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_a_raw,
    input  logic btn_b_raw,
    output logic a,
    output logic b,
    output logic a_rise,
    output logic a_fall,
    output logic b_rise,
    output logic b_fall
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic [1:0] raw;
    assign raw = {btn_b_raw, btn_a_raw};

    for (genvar i = 0; i < 2; i++) begin : ch
        logic                 s1;
        logic                 s2;
        logic                 lvl;
        logic                 rise;
        logic                 fall;
        logic [CNT_WIDTH-1:0] cnt;

        always_ff @(posedge clk) begin
            if (rst) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                lvl  <= 1'b0;
                rise <= 1'b0;
                fall <= 1'b0;
                cnt  <= '0;
            end else begin
                s1   <= raw[i];
                s2   <= s1;
                rise <= 1'b0;
                fall <= 1'b0;
                // A return to the current level aborts any pending change.
                if (s2 == lvl) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    lvl  <= s2;
                    cnt  <= '0;
                    rise <= s2;
                    fall <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign a      = ch[0].lvl;
    assign a_rise = ch[0].rise;
    assign a_fall = ch[0].fall;
    assign b      = ch[1].lvl;
    assign b_rise = ch[1].rise;
    assign b_fall = ch[1].fall;

endmodule

// File: tb/tb_btn_pair_debounce.sv
// Scoreboard bench for btn_pair_debounce with DEBOUNCE_CYCLES=4 (6-edge raw-to-output latency).
module tb_btn_pair_debounce;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_a_raw = 1'b1;
    logic btn_b_raw = 1'b1;
    logic a, b, a_rise, a_fall, b_rise, b_fall;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] p;   // {a_rise, a_fall, b_rise, b_fall}
        logic [1:0] lv;  // {a, b}
    } ev_t;

    ev_t exp_q[$];

    btn_pair_debounce #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst),
        .btn_a_raw(btn_a_raw), .btn_b_raw(btn_b_raw),
        .a(a), .b(b),
        .a_rise(a_rise), .a_fall(a_fall),
        .b_rise(b_rise), .b_fall(b_fall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // Monitor: every pulse must match the head of the expected-event queue.
    always @(negedge clk) begin
        logic [3:0] p;
        ev_t e;
        p = {a_rise, a_fall, b_rise, b_fall};
        if (p != 4'b0) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_pulse: got pulses=%b levels=%b at cyc %0d, required none",
                         p, {a, b}, cyc);
            end else begin
                e = exp_q.pop_front();
                total++;
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL event_time: pulse at cyc %0d, required cyc %0d", cyc, e.cyc);
                end
                total++;
                if (p != e.p || {a, b} != e.lv) begin
                    bad++;
                    $display("FAIL event_value: pulses=%b levels=%b, required pulses=%b levels=%b",
                             p, {a, b}, e.p, e.lv);
                end
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].cyc) begin
            e = exp_q.pop_front();
            total++; bad++;
            $display("FAIL missing_event: no pulse by cyc %0d, required pulses=%b at cyc %0d",
                     cyc, e.p, e.cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_ev(input int off, input logic [3:0] p, input logic [1:0] lv);
        ev_t e;
        e.cyc = cyc + off;
        e.p   = p;
        e.lv  = lv;
        exp_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    initial begin
        // Reset with both raw inputs high: everything held at zero.
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("reset_outputs", {26'd0, a, b, a_rise, a_fall, b_rise, b_fall}, 32'd0);
        end
        rst = 1'b0;
        expect_ev(6, 4'b1010, 2'b11);
        step(10);
        check("post_reset_levels", {30'd0, a, b}, 32'b11);

        // Simultaneous release on both channels.
        btn_a_raw = 1'b0; btn_b_raw = 1'b0;
        expect_ev(6, 4'b0101, 2'b00);
        step(10);
        check("release_levels", {30'd0, a, b}, 32'b00);

        // Clean press on A; B untouched.
        btn_a_raw = 1'b1;
        expect_ev(6, 4'b1000, 2'b10);
        step(10);
        check("press_a_levels", {30'd0, a, b}, 32'b10);

        // Clean release of A to set up the bounce case.
        btn_a_raw = 1'b0;
        expect_ev(6, 4'b0100, 2'b00);
        step(10);
        check("release_a_level", {31'd0, a}, 32'd0);

        // Bounce on A: 1,0,1,0 then hold 1.
        btn_a_raw = 1'b1; step(1);
        btn_a_raw = 1'b0; step(1);
        btn_a_raw = 1'b1; step(1);
        btn_a_raw = 1'b0; step(1);
        btn_a_raw = 1'b1;
        expect_ev(6, 4'b1000, 2'b10);
        step(10);
        check("bounce_a_level", {31'd0, a}, 32'd1);

        // Glitch on B: high for 3 cycles is rejected.
        btn_b_raw = 1'b1; step(3);
        btn_b_raw = 1'b0;
        step(10);
        check("glitch_b_level", {31'd0, b}, 32'd0);
        check("glitch_b_cnt", 32'(dut.ch[1].cnt), 32'd0);

        // Release A, then reset in the middle of a press count.
        btn_a_raw = 1'b0;
        expect_ev(6, 4'b0100, 2'b00);
        step(10);
        btn_a_raw = 1'b1;
        step(3);
        rst = 1'b1;
        step(1);
        check("midreset_a", {29'd0, a, a_rise, a_fall}, 32'd0);
        rst = 1'b0;
        expect_ev(6, 4'b1000, 2'b10);
        step(3);
        check("midreset_a_pending", {31'd0, a}, 32'd0);
        step(7);
        check("midreset_a_level", {31'd0, a}, 32'd1);

        step(2);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
